// File: rtl/lc3_mem_responder.sv
// Memory responder for the LC3 fetch and data ports: shared word array, per-channel wait states.
// Optional out-of-range trap enabled with `define LC3_MEM_OOR_TRAP_EN.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int unsigned T_FETCH   = 0,
  parameter int unsigned T_DATA    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        Data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        oor_err
);

  localparam int unsigned Depth     = 2 ** ADDR_W;
  localparam logic [7:0]  CntFetch  = 8'(T_FETCH);
  localparam logic [7:0]  CntData   = 8'(T_DATA);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [15:0] mem [Depth];

  // Fetch channel
  state_e      f_state_q, f_state_d;
  logic [7:0]  f_cnt_q, f_cnt_d;
  logic [15:0] f_addr_q, f_addr_d;
  logic [15:0] f_sel_addr;
  logic        f_fire;

  // Data channel
  state_e      d_state_q, d_state_d;
  logic [7:0]  d_cnt_q, d_cnt_d;
  logic [15:0] d_addr_q, d_addr_d;
  logic        d_rd_q, d_rd_d;
  logic [15:0] d_din_q, d_din_d;
  logic [15:0] d_sel_addr;
  logic        d_sel_rd;
  logic [15:0] d_sel_din;
  logic        d_fire;

  logic [ADDR_W-1:0] f_idx, d_idx, load_idx;
  logic              f_oor, d_oor, load_oor;

  assign f_idx    = ADDR_W'(f_sel_addr - BASE_ADDR);
  assign d_idx    = ADDR_W'(d_sel_addr - BASE_ADDR);
  assign load_idx = ADDR_W'(load_addr - BASE_ADDR);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_state_q <= StIdle;
      f_cnt_q   <= '0;
      f_addr_q  <= '0;
    end else begin
      f_state_q <= f_state_d;
      f_cnt_q   <= f_cnt_d;
      f_addr_q  <= f_addr_d;
    end
  end

  // f_sel_addr is the address used on the edge entering DONE: the live pc when
  // a zero-wait request goes straight to DONE, otherwise the latched one.
  always_comb begin
    f_state_d  = f_state_q;
    f_cnt_d    = f_cnt_q;
    f_addr_d   = f_addr_q;
    f_sel_addr = f_addr_q;
    f_fire     = 1'b0;
    unique case (f_state_q)
      StIdle, StDone: begin
        f_state_d = StIdle;
        if (instrmem_rd) begin
          f_addr_d   = pc;
          f_sel_addr = pc;
          if (T_FETCH == 0) begin
            f_state_d = StDone;
            f_fire    = 1'b1;
          end else begin
            f_cnt_d   = CntFetch;
            f_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (f_cnt_q <= 8'd1) begin
          f_cnt_d   = '0;
          f_state_d = StDone;
          f_fire    = 1'b1;
        end else begin
          f_cnt_d = f_cnt_q - 8'd1;
        end
      end
      default: f_state_d = StIdle;
    endcase
  end

  always_comb begin
    complete_instr = (f_state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Data FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_state_q <= StIdle;
      d_cnt_q   <= '0;
      d_addr_q  <= '0;
      d_rd_q    <= 1'b0;
      d_din_q   <= '0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_addr_q  <= d_addr_d;
      d_rd_q    <= d_rd_d;
      d_din_q   <= d_din_d;
    end
  end

  always_comb begin
    d_state_d  = d_state_q;
    d_cnt_d    = d_cnt_q;
    d_addr_d   = d_addr_q;
    d_rd_d     = d_rd_q;
    d_din_d    = d_din_q;
    d_sel_addr = d_addr_q;
    d_sel_rd   = d_rd_q;
    d_sel_din  = d_din_q;
    d_fire     = 1'b0;
    unique case (d_state_q)
      StIdle, StDone: begin
        d_state_d = StIdle;
        if (Data_en) begin
          d_addr_d   = Data_addr;
          d_rd_d     = Data_rd;
          d_din_d    = Data_din;
          d_sel_addr = Data_addr;
          d_sel_rd   = Data_rd;
          d_sel_din  = Data_din;
          if (T_DATA == 0) begin
            d_state_d = StDone;
            d_fire    = 1'b1;
          end else begin
            d_cnt_d   = CntData;
            d_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (d_cnt_q <= 8'd1) begin
          d_cnt_d   = '0;
          d_state_d = StDone;
          d_fire    = 1'b1;
        end else begin
          d_cnt_d = d_cnt_q - 8'd1;
        end
      end
      default: d_state_d = StIdle;
    endcase
  end

  always_comb begin
    complete_data = (d_state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Out-of-range trap
  // ---------------------------------------------------------------------------
`ifdef LC3_MEM_OOR_TRAP_EN
  logic oor_q;

  assign f_oor    = ((f_sel_addr - BASE_ADDR) >> ADDR_W) != 16'd0;
  assign d_oor    = ((d_sel_addr - BASE_ADDR) >> ADDR_W) != 16'd0;
  assign load_oor = ((load_addr - BASE_ADDR) >> ADDR_W) != 16'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oor_q <= 1'b0;
    end else if ((f_fire && f_oor) || (d_fire && d_oor) || (load_en && load_oor)) begin
      oor_q <= 1'b1;
    end
  end

  assign oor_err = oor_q;
`else
  assign f_oor    = 1'b0;
  assign d_oor    = 1'b0;
  assign load_oor = 1'b0;
  assign oor_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Array: data write is ordered after the load so it wins on a shared index.
  // The reset gate keeps an aborted zero-wait write from committing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (load_en && !load_oor) begin
      mem[load_idx] <= load_data;
    end
    if (reset && d_fire && !d_sel_rd && !d_oor) begin
      mem[d_idx] <= d_sel_din;
    end
  end

  // Reads sample the array before this edge's write, so a colliding fetch sees the old word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (f_fire) begin
        Instr_dout <= f_oor ? 16'h0000 : mem[f_idx];
      end
      if (d_fire && d_sel_rd) begin
        Data_dout <= d_oor ? 16'h0000 : mem[d_idx];
      end
    end
  end

endmodule
